// File: rtl/fetch_stage_if.sv
// Fetch -> decode pipeline register bundle: instruction word plus its PC+4.
// Latency: pure wiring, no state.
// Backpressure: none here; the fetch stage advances the register only when en=1.
interface fetch_stage_if;
  logic [31:0] instruction;
  logic [31:0] instr_npc;

  // Fetch stage drives the register contents.
  modport master (output instruction, output instr_npc);
  // Decode stage consumes them.
  modport slave (input instruction, input instr_npc);
endinterface

// File: rtl/fetch_stage.sv
// Fetch stage: PC register, instruction memory request, and the fetch/decode register.
// Latency: ihit at cycle N with en=1 shows the word on out.instruction at N+1.
// Backpressure: en=0 freezes pc and out; FETCH_HOLD_BUF_EN adds a one-entry hold buffer for stalled ihits.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h00000000
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          en,
  input  logic          flush,
  input  logic          redirect,
  input  logic [31:0]   redirect_target,
  input  logic          halt,
  input  logic          ihit,
  input  logic [31:0]   imemload,
  output logic          imemREN,
  output logic [31:0]   imemaddr,
  output logic          fetch_stall,
  fetch_stage_if.master out
);

  typedef enum logic {FETCH, HALTED} state_t;

  state_t      state, next_state;
  logic [31:0] pc, next_pc;
  logic [31:0] pc_plus4;
  logic [31:0] instr_q, next_instr;
  logic [31:0] npc_q, next_npc;
  logic        avail;

`ifdef FETCH_HOLD_BUF_EN
  logic        buf_valid, next_buf_valid;
  logic [31:0] buf_word, next_buf_word;

  // A buffered word counts as available, and no new read is issued while one is held.
  assign avail   = ihit | buf_valid;
  assign imemREN = (state == FETCH) & ~buf_valid;
`else
  // Without the buffer a stalled ihit is dropped and the same address is simply re-read.
  assign avail   = ihit;
  assign imemREN = (state == FETCH);
`endif

  assign pc_plus4        = pc + 32'd4;
  assign imemaddr        = pc;
  assign out.instruction = instr_q;
  assign out.instr_npc   = npc_q;
  assign fetch_stall     = en & ~avail & (state == FETCH) & ~redirect & ~flush;

  // Next-state and next-register selection; halt outranks redirect/flush/avail/bubble.
  always_comb begin
    next_state = state;
    next_pc    = pc;
    next_instr = instr_q;
    next_npc   = npc_q;
`ifdef FETCH_HOLD_BUF_EN
    next_buf_valid = buf_valid;
    next_buf_word  = buf_word;
`endif
    if (state == FETCH) begin
      if (halt) begin
        next_state = HALTED;
      end else if (en) begin
        if (redirect) begin
          // Taken branch/jump: squash whatever arrived this cycle and drop the buffer.
          next_pc    = redirect_target;
          next_instr = 32'd0;
          next_npc   = 32'd0;
`ifdef FETCH_HOLD_BUF_EN
          next_buf_valid = 1'b0;
`endif
        end else if (flush) begin
          // Squash to NOP; pc and any buffered word stay for the next advance.
          next_instr = 32'd0;
          next_npc   = 32'd0;
        end else if (avail) begin
`ifdef FETCH_HOLD_BUF_EN
          next_instr     = buf_valid ? buf_word : imemload;
          next_buf_valid = 1'b0;
`else
          next_instr = imemload;
`endif
          next_npc = pc_plus4;
          next_pc  = pc_plus4;
        end else begin
          // Memory not ready: insert a bubble.
          next_instr = 32'd0;
          next_npc   = 32'd0;
        end
      end
`ifdef FETCH_HOLD_BUF_EN
      else if (ihit && !buf_valid) begin
        next_buf_valid = 1'b1;
        next_buf_word  = imemload;
      end
`endif
    end
  end

  // State and datapath registers with synchronous active-high reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= FETCH;
      pc      <= RESET_PC;
      instr_q <= 32'd0;
      npc_q   <= 32'd0;
`ifdef FETCH_HOLD_BUF_EN
      buf_valid <= 1'b0;
      buf_word  <= 32'd0;
`endif
    end else begin
      state   <= next_state;
      pc      <= next_pc;
      instr_q <= next_instr;
      npc_q   <= next_npc;
`ifdef FETCH_HOLD_BUF_EN
      buf_valid <= next_buf_valid;
      buf_word  <= next_buf_word;
`endif
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: reset, streaming fetch, redirect, stall, flush,
// en=0 hold (with and without FETCH_HOLD_BUF_EN), halt, and PC wrap.
// Inputs change 1ns after the rising edge; outputs are checked there too.
module tb_fetch_stage;
  logic        CLK = 1'b0;
  logic        RST;
  logic        en, flush, redirect, halt, ihit;
  logic [31:0] redirect_target, imemload;
  logic        imemREN, fetch_stall;
  logic [31:0] imemaddr;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_stage_if fd_if ();

  fetch_stage #(.RESET_PC(32'h00000000)) dut (
    .CLK            (CLK),
    .RST            (RST),
    .en             (en),
    .flush          (flush),
    .redirect       (redirect),
    .redirect_target(redirect_target),
    .halt           (halt),
    .ihit           (ihit),
    .imemload       (imemload),
    .imemREN        (imemREN),
    .imemaddr       (imemaddr),
    .fetch_stall    (fetch_stall),
    .out            (fd_if.master)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Set inputs for the coming edge and let combinational outputs settle.
  task automatic drive(input logic e, input logic fl, input logic rd, input logic [31:0] tgt,
                       input logic h, input logic hit, input logic [31:0] word);
    en = e; flush = fl; redirect = rd; redirect_target = tgt;
    halt = h; ihit = hit; imemload = word;
    #1;
  endtask

  initial begin
    RST = 1'b1;
    drive(0, 0, 0, 32'h0, 0, 0, 32'h0);
    tick();
    tick();
    RST = 1'b0;
    #1;
    // Reset state
    check("rst_instr", fd_if.instruction, 32'h0);
    check("rst_npc", fd_if.instr_npc, 32'h0);
    check("rst_addr", imemaddr, 32'h0);
    check("rst_ren", {31'd0, imemREN}, 32'd1);

    // Streaming fetch from RESET_PC
    drive(1, 0, 0, 32'h0, 0, 1, 32'h20010005);
    check("stream_stall", {31'd0, fetch_stall}, 32'd0);
    tick();
    check("stream_instr", fd_if.instruction, 32'h20010005);
    check("stream_npc0", fd_if.instr_npc, 32'h4);
    check("stream_addr0", imemaddr, 32'h4);
    tick();
    check("stream_npc1", fd_if.instr_npc, 32'h8);
    check("stream_addr1", imemaddr, 32'h8);

    // Redirect to 0x40, then redirect again to 0x100 with a concurrent ihit
    drive(1, 0, 1, 32'h40, 0, 1, 32'hDEADBEEF);
    tick();
    check("redir40_addr", imemaddr, 32'h40);
    drive(1, 0, 1, 32'h100, 0, 1, 32'hDEADBEEF);
    check("redir_stall", {31'd0, fetch_stall}, 32'd0);
    tick();
    check("redir_instr", fd_if.instruction, 32'h0);
    check("redir_npc", fd_if.instr_npc, 32'h0);
    check("redir_addr", imemaddr, 32'h100);
    drive(1, 0, 0, 32'h0, 0, 1, 32'h11112222);
    tick();
    check("redir_next_instr", fd_if.instruction, 32'h11112222);
    check("redir_next_npc", fd_if.instr_npc, 32'h104);

    // Stall at 0x40 for three cycles after a real instruction
    drive(1, 0, 1, 32'h3C, 0, 0, 32'h0);
    tick();
    drive(1, 0, 0, 32'h0, 0, 1, 32'hAAAA0001);
    tick();
    check("pre_stall_instr", fd_if.instruction, 32'hAAAA0001);
    drive(1, 0, 0, 32'h0, 0, 0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      check("stall_flag", {31'd0, fetch_stall}, 32'd1);
      tick();
      check("stall_bubble", fd_if.instruction, 32'h0);
      check("stall_addr", imemaddr, 32'h40);
    end

    // Flush: load a word, then flush with ihit present; pc must not advance
    drive(1, 0, 0, 32'h0, 0, 1, 32'hBBBB0002);
    tick();
    check("pre_flush_npc", fd_if.instr_npc, 32'h44);
    drive(1, 1, 0, 32'h0, 0, 1, 32'hCCCC0003);
    check("flush_stall", {31'd0, fetch_stall}, 32'd0);
    tick();
    check("flush_instr", fd_if.instruction, 32'h0);
    check("flush_addr", imemaddr, 32'h44);

    // en=0 with ihit at pc=0x20; redirect must be ignored
    drive(1, 0, 1, 32'h1C, 0, 0, 32'h0);
    tick();
    drive(1, 0, 0, 32'h0, 0, 1, 32'h12345678);
    tick();
    drive(0, 0, 1, 32'h500, 0, 1, 32'h8C220000);
    tick();
    check("hold_instr", fd_if.instruction, 32'h12345678);
    check("hold_npc", fd_if.instr_npc, 32'h20);
    check("hold_addr", imemaddr, 32'h20);
`ifdef FETCH_HOLD_BUF_EN
    check("hold_ren", {31'd0, imemREN}, 32'd0);
    drive(1, 0, 0, 32'h0, 0, 0, 32'h0);
    check("buf_stall", {31'd0, fetch_stall}, 32'd0);
    tick();
    check("buf_instr", fd_if.instruction, 32'h8C220000);
    check("buf_npc", fd_if.instr_npc, 32'h24);
    check("buf_addr", imemaddr, 32'h24);
    check("buf_ren", {31'd0, imemREN}, 32'd1);
`else
    check("hold_ren", {31'd0, imemREN}, 32'd1);
    drive(1, 0, 0, 32'h0, 0, 0, 32'h0);
    check("nobuf_stall", {31'd0, fetch_stall}, 32'd1);
    tick();
    check("nobuf_instr", fd_if.instruction, 32'h0);
    check("nobuf_addr", imemaddr, 32'h20);
    drive(1, 0, 0, 32'h0, 0, 1, 32'h8C220000);
    tick();
    check("reread_instr", fd_if.instruction, 32'h8C220000);
    check("reread_npc", fd_if.instr_npc, 32'h24);
`endif

    // Halt at pc=0x80, then ten cycles of en/redirect/ihit that must be ignored
    drive(1, 0, 1, 32'h80, 0, 0, 32'h0);
    tick();
    drive(1, 0, 0, 32'h0, 1, 1, 32'h55550000);
    tick();
    check("halt_ren", {31'd0, imemREN}, 32'd0);
    drive(1, 0, 1, 32'h999, 0, 1, 32'h66660000);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("halted_addr", imemaddr, 32'h80);
      check("halted_ren", {31'd0, imemREN}, 32'd0);
    end
    check("halted_instr", fd_if.instruction, 32'h0);
    check("halted_stall", {31'd0, fetch_stall}, 32'd0);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    drive(0, 0, 0, 32'h0, 0, 0, 32'h0);
    check("unhalt_addr", imemaddr, 32'h0);
    check("unhalt_ren", {31'd0, imemREN}, 32'd1);

    // PC wrap at the top of the address space
    drive(1, 0, 1, 32'hFFFFFFFC, 0, 0, 32'h0);
    tick();
    check("wrap_pre_addr", imemaddr, 32'hFFFFFFFC);
    drive(1, 0, 0, 32'h0, 0, 1, 32'h77770004);
    tick();
    check("wrap_instr", fd_if.instruction, 32'h77770004);
    check("wrap_npc", fd_if.instr_npc, 32'h0);
    check("wrap_addr", imemaddr, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
